rtc_apb_regif: RTL and testbench

//  APB3 register interface for the RTC up-counter. Drives its load port
//  (wr/initialvalue), takes its sec/min/hour/day/month outputs, and gives the

---
 rtl/rtc_apb_regif_if.sv | 24 ++
 rtl/rtc_apb_regif.sv | 127 ++++++++++++
 tb/tb_rtc_apb_regif.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_apb_regif_if.sv
// APB3 bus bundle between the RISC-V core and the RTC register interface.
// Only PADDR[4:2] is decoded by the slave; the width covers the full byte address.
interface rtc_apb_regif_if #(
    parameter int ADDR_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/rtc_apb_regif.sv
// APB3 register interface for the RTC counter: load port, coherent time shadow,
// alarm comparator with sticky flag and level interrupt.
//
// state  | meaning
// S_IDLE | no transfer in progress
// S_WAIT | the single wait state; PSEL drop here aborts
// S_DONE | PREADY=1, write committed at end of cycle or PRDATA presented
module rtc_apb_regif #(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    rtc_apb_regif_if.slave        apb,
    input  logic [5:0]            i_sec,
    input  logic [5:0]            i_min,
    input  logic [4:0]            i_hour,
    input  logic [4:0]            i_day,
    input  logic [3:0]            i_month,
    output logic                  o_wr,
    output logic [25:0]           o_initialvalue,
    output logic                  o_irq
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [2:0]  A_TIME   = 3'd0;
    localparam logic [2:0]  A_ALARM  = 3'd1;
    localparam logic [2:0]  A_CTRL   = 3'd2;
    localparam logic [2:0]  A_STATUS = 3'd3;
    localparam logic [2:0]  A_ID     = 3'd4;
    localparam logic [31:0] ID_VALUE = 32'h5254_0001;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [25:0] r_alarm;
    logic [1:0]  r_ctrl;
    logic        r_alarm_flag;
    logic [25:0] r_cur_d;
    logic [25:0] r_shadow;
    logic [25:0] r_shadow_prev;
    logic        r_wr;
    logic [25:0] r_initialvalue;

    logic [2:0]  w_off;
    logic        w_mapped;
    logic        w_commit;
    logic [25:0] w_cur;
    logic        w_match;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    assign w_off    = apb.PADDR[4:2];
    assign w_mapped = (w_off <= A_ID);
    assign w_commit = (r_state == S_DONE) && apb.PWRITE && w_mapped;
    assign w_cur    = {i_month, i_day, i_hour, i_min, i_sec};
    // Fires only on the cycle the shadow moves onto the alarm value.
    assign w_match  = r_ctrl[0] && (r_shadow == r_alarm) && (r_shadow != r_shadow_prev);

    assign w_unused_bits = ^{apb.PADDR[ADDR_W-1:5], apb.PADDR[1:0], apb.PWDATA[31:26]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (apb.PSEL && apb.PENABLE) w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = apb.PSEL ? S_DONE : S_IDLE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'd0;
        unique case (w_off)
            A_TIME:   w_rdata = {6'd0, r_shadow};
            A_ALARM:  w_rdata = {6'd0, r_alarm};
            A_CTRL:   w_rdata = {30'd0, r_ctrl};
            A_STATUS: w_rdata = {31'd0, r_alarm_flag};
            A_ID:     w_rdata = ID_VALUE;
            default:  w_rdata = 32'd0;
        endcase
    end

    always_comb begin
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = 32'd0;
        if (r_state == S_DONE) begin
            apb.PREADY = 1'b1;
            if (!w_mapped)         apb.PSLVERR = 1'b1;
            else if (!apb.PWRITE)  apb.PRDATA  = w_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr           <= 1'b0;
            r_initialvalue <= 26'd0;
            r_alarm        <= 26'd0;
            r_ctrl         <= 2'd0;
            r_alarm_flag   <= 1'b0;
            r_cur_d        <= 26'd0;
            r_shadow       <= 26'd0;
            r_shadow_prev  <= 26'd0;
        end else begin
            r_wr <= w_commit && (w_off == A_TIME);
            if (w_commit && (w_off == A_TIME))  r_initialvalue <= apb.PWDATA[25:0];
            if (w_commit && (w_off == A_ALARM)) r_alarm        <= apb.PWDATA[25:0];
            if (w_commit && (w_off == A_CTRL))  r_ctrl         <= apb.PWDATA[1:0];
            if (w_match)
                r_alarm_flag <= 1'b1;
            else if (w_commit && (w_off == A_STATUS) && apb.PWDATA[0])
                r_alarm_flag <= 1'b0;
            // Carries ripple one field per cycle; accept only a value held for two cycles.
            r_cur_d       <= w_cur;
            r_shadow_prev <= r_shadow;
            if (w_cur == r_cur_d) r_shadow <= w_cur;
        end
    end

    assign o_wr           = r_wr;
    assign o_initialvalue = r_initialvalue;
    assign o_irq          = r_alarm_flag & r_ctrl[1];
endmodule

// File: tb/tb_rtc_apb_regif.sv
// Directed plus randomized bench for rtc_apb_regif against a transaction-level
// model of the register map, coherent shadow and alarm flag.
module tb_rtc_apb_regif;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  i_sec, i_min;
    logic [4:0]  i_hour, i_day;
    logic [3:0]  i_month;
    logic        o_wr;
    logic [25:0] o_initialvalue;
    logic        o_irq;

    always #5 clk = ~clk;

    rtc_apb_regif_if #(.ADDR_W(8)) apb ();

    rtc_apb_regif #(.ADDR_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .apb            (apb),
        .i_sec          (i_sec),
        .i_min          (i_min),
        .i_hour         (i_hour),
        .i_day          (i_day),
        .i_month        (i_month),
        .o_wr           (o_wr),
        .o_initialvalue (o_initialvalue),
        .o_irq          (o_irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: register contents, settled time, alarm flag.
    logic [25:0] m_alarm, m_shadow, m_prev, m_curd, cur_v;
    logic [1:0]  m_ctrl;
    logic        m_flag, mt_v;
    int          p_seq = 0;
    int          p_done = 0;
    logic [2:0]  p_off;
    logic [31:0] p_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_alarm = '0; m_shadow = '0; m_prev = '0; m_curd = '0;
            m_ctrl = '0; m_flag = 1'b0; p_done = p_seq;
        end else begin
            mt_v = m_ctrl[0] && (m_shadow == m_alarm) && (m_shadow != m_prev);
            if (p_done != p_seq) begin
                p_done = p_seq;
                case (p_off)
                    3'd1: m_alarm = p_data[25:0];
                    3'd2: m_ctrl  = p_data[1:0];
                    3'd3: if (p_data[0]) m_flag = 1'b0;
                    default: ;
                endcase
            end
            if (mt_v) m_flag = 1'b1;
            m_prev = m_shadow;
            cur_v  = {i_month, i_day, i_hour, i_min, i_sec};
            if (cur_v == m_curd) m_shadow = cur_v;
            m_curd = cur_v;
        end
    end

    int wr_cnt = 0;
    always @(negedge clk) if (!reset && o_wr) wr_cnt++;

    function automatic logic [31:0] exp_read(input logic [2:0] off);
        case (off)
            3'd0:    return {6'd0, m_shadow};
            3'd1:    return {6'd0, m_alarm};
            3'd2:    return {30'd0, m_ctrl};
            3'd3:    return {31'd0, m_flag};
            3'd4:    return 32'h5254_0001;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [25:0] now_t();
        return {i_month, i_day, i_hour, i_min, i_sec};
    endfunction

    // Caller sits #1 after a rising edge; returns #1 after the edge that ends DONE.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
        int n;
        apb.PSEL = 1'b1; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wdata; apb.PENABLE = 1'b0;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!apb.PREADY && n < 10);
        check("pready_latency", 32'(n), 32'd2);
        rdata = apb.PRDATA;
        err   = apb.PSLVERR;
        check("pslverr", 32'(err), 32'(addr[4:2] > 3'd4));
        if (!wr) check("prdata", rdata, exp_read(addr[4:2]));
        if (wr && apb.PREADY) begin
            p_off = addr[4:2]; p_data = wdata; p_seq++;
        end
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("irq_level", 32'(o_irq), 32'(m_flag & m_ctrl[1]));
        end
    endtask

    // RTC advance by one second, carrying one field per clock.
    task automatic tick();
        int  st;
        bit  carry;
        st = 0; carry = 1'b1;
        while (carry && st < 5) begin
            @(posedge clk); #1;
            case (st)
                0: begin carry = (i_sec == 6'd59);   i_sec   = carry ? 6'd0 : i_sec + 6'd1;   end
                1: begin carry = (i_min == 6'd59);   i_min   = carry ? 6'd0 : i_min + 6'd1;   end
                2: begin carry = (i_hour == 5'd23);  i_hour  = carry ? 5'd0 : i_hour + 5'd1;  end
                3: begin carry = (i_day == 5'd30);   i_day   = carry ? 5'd0 : i_day + 5'd1;   end
                default: begin carry = 1'b0; i_month = (i_month == 4'd11) ? 4'd0 : i_month + 4'd1; end
            endcase
            st++;
        end
    endtask

    logic [31:0] rd_v;
    logic        err_v;
    int          wr_before;
    logic [7:0]  ra;

    initial begin
        reset = 1'b1;
        i_sec = '0; i_min = '0; i_hour = '0; i_day = '0; i_month = '0;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_wr", 32'(o_wr), 32'd0);
        check("rst_initialvalue", 32'(o_initialvalue), 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_pready", 32'(apb.PREADY), 32'd0);
        check("rst_prdata", apb.PRDATA, 32'd0);
        check("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
        reset = 1'b0;
        idle(3);

        xfer(1'b0, 8'h10, 32'd0, rd_v, err_v);
        check("id_value", rd_v, 32'h5254_0001);
        check("id_err", 32'(err_v), 32'd0);

        // TIME write: one-cycle load strobe right after DONE
        wr_before = wr_cnt;
        xfer(1'b1, 8'h00, 32'h0000_003B, rd_v, err_v);
        check("time_wr_high", 32'(o_wr), 32'd1);
        check("time_wr_value", 32'(o_initialvalue), 32'h3B);
        @(posedge clk); #1;
        check("time_wr_low", 32'(o_wr), 32'd0);
        i_min = 6'd0; i_sec = 6'd59;
        idle(4);
        check("time_wr_count", 32'(wr_cnt - wr_before), 32'd1);
        check("time_iv_hold", 32'(o_initialvalue), 32'h3B);
        xfer(1'b0, 8'h00, 32'd0, rd_v, err_v);
        check("time_read", rd_v, 32'h3B);

        // sec 59->0 with min 4->5 one cycle later, read landing at each phase
        for (int ph = 0; ph < 6; ph++) begin
            i_min = 6'd4; i_sec = 6'd59;
            idle(4);
            fork
                xfer(1'b0, 8'h00, 32'd0, rd_v, err_v);
                begin repeat (ph) @(posedge clk); tick(); end
            join
            check("coherent_read", 32'((rd_v == 32'h13B) || (rd_v == 32'h140)), 32'd1);
        end
        idle(4);

        // alarm one second ahead, irq enabled
        xfer(1'b1, 8'h04, {6'd0, now_t() + 26'd1}, rd_v, err_v);
        xfer(1'b1, 8'h08, 32'd3, rd_v, err_v);
        idle(3);
        check("alarm_pre_irq", 32'(o_irq), 32'd0);
        tick();
        idle(4);
        check("alarm_irq", 32'(o_irq), 32'd1);
        xfer(1'b0, 8'h0C, 32'd0, rd_v, err_v);
        check("alarm_status", rd_v, 32'd1);
        xfer(1'b1, 8'h0C, 32'd1, rd_v, err_v);
        idle(1);
        check("w1c_irq", 32'(o_irq), 32'd0);
        idle(10);
        check("no_refire", 32'(o_irq), 32'd0);

        // W1C committing in the same cycle as the match pulse
        xfer(1'b1, 8'h04, {6'd0, now_t() + 26'd1}, rd_v, err_v);
        idle(3);
        fork
            xfer(1'b1, 8'h0C, 32'd1, rd_v, err_v);
            begin @(posedge clk); #1; i_sec = i_sec + 6'd1; end
        join
        idle(1);
        xfer(1'b0, 8'h0C, 32'd0, rd_v, err_v);
        check("set_wins", rd_v, 32'd1);
        xfer(1'b1, 8'h0C, 32'd1, rd_v, err_v);

        // unmapped offset
        xfer(1'b0, 8'h18, 32'd0, rd_v, err_v);
        check("unmapped_rdata", rd_v, 32'd0);
        check("unmapped_err", 32'(err_v), 32'd1);
        xfer(1'b1, 8'h18, 32'hFFFF_FFFF, rd_v, err_v);
        xfer(1'b0, 8'h08, 32'd0, rd_v, err_v);
        check("unmapped_ctrl_kept", rd_v, 32'd3);

        // reset asserted in WAIT of a TIME write
        wr_before = wr_cnt;
        apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 8'h00; apb.PWDATA = 32'h0012_3456; apb.PENABLE = 1'b0;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("midrst_pready", 32'(apb.PREADY), 32'd0);
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        reset = 1'b0;
        idle(5);
        check("midrst_no_wr", 32'(wr_cnt - wr_before), 32'd0);
        check("midrst_iv", 32'(o_initialvalue), 32'd0);

        // randomized traffic against the model
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 5))
                0: begin
                    if ($urandom_range(0, 1) == 1 && i_sec < 6'd59)
                        xfer(1'b1, 8'h04, {6'd0, now_t() + 26'd1}, rd_v, err_v);
                    else
                        xfer(1'b1, 8'h04, $urandom, rd_v, err_v);
                end
                1: xfer(1'b1, 8'h08, 32'($urandom_range(0, 3)), rd_v, err_v);
                2: xfer(1'b1, 8'h0C, 32'($urandom_range(0, 1)), rd_v, err_v);
                3: begin
                    ra = 8'($urandom_range(0, 255));
                    xfer(1'($urandom_range(0, 1)), ra, $urandom, rd_v, err_v);
                end
                4: tick();
                default: idle($urandom_range(1, 6));
            endcase
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
